// File: rtl/branch_resolve_queue_pkg.sv
// Shared types for the branch resolve queue: queue entry layout, FSM states
// and the commit-time mispredict test.
package branch_resolve_queue_pkg;

    localparam int BRQ_DEPTH = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } brq_entry_t;

    typedef enum logic {BRQ_RUN = 1'b0, BRQ_FLUSH = 1'b1} brq_state_t;

    // Only the next PC matters; a direction mismatch that lands on the same PC is harmless.
    function automatic logic brq_mispredict(input brq_entry_t entry, input logic [31:0] next_pc);
        return (entry.target != next_pc);
    endfunction

endpackage

// File: rtl/branch_resolve_queue_circ_queue.sv
// Generic in-order circular queue with push, pop and a single-cycle clear.
// The head entry is presented combinationally.
module circ_queue #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  T                         push_data,
    input  logic                     pop,
    input  logic                     clear,
    output T                         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    T              mem_r [DEPTH];
    logic [AW-1:0] head_r;
    logic [AW-1:0] tail_r;
    logic [CW-1:0] count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign full      = (count_r == DEPTH_C);
    assign empty     = (count_r == {CW{1'b0}});
    assign count     = count_r;
    assign head_data = mem_r[head_r];
    // A pop frees the slot in the same cycle, so a push into a full queue is fine alongside it.
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);

    // Pointer and occupancy bookkeeping; clear discards every entry at once.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            head_r  <= {AW{1'b0}};
            tail_r  <= {AW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (do_push_s) tail_r <= tail_r + AW'(1);
            if (do_pop_s)  head_r <= head_r + AW'(1);
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; needs no reset because occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[tail_r] <= push_data;
    end

endmodule

// File: rtl/branch_resolve_queue.sv
// Program-order queue of branch predictions: resolves each against the ROB commit,
// drives the predictor update port and the frontend flush/redirect.
module branch_resolve_queue
    import branch_resolve_queue_pkg::*;
#(
    parameter int DEPTH = BRQ_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pred_valid,
    input  logic [31:0] pred_pc,
    input  logic        pred_taken,
    input  logic [31:0] pred_target,
    output logic        full,
    input  logic        commit_valid,
    input  logic        commit_taken,
    input  logic [31:0] commit_next_pc,
    output logic        upd_load,
    output logic [31:0] upd_pc,
    output logic        upd_taken,
    output logic        flush,
    output logic [31:0] flush_pc,
    output logic        err
);

    localparam int CW = $clog2(DEPTH) + 1;

    brq_state_t    state_r;
    brq_state_t    state_next_s;
    brq_entry_t    push_entry_s;
    brq_entry_t    head_s;
    logic [CW-1:0] count_s;
    logic          q_full_s;
    logic          empty_s;
    logic          push_s;
    logic          pop_s;
    logic          clear_s;
    logic          mispredict_s;
    logic          err_set_s;

    logic          upd_load_r;
    logic [31:0]   upd_pc_r;
    logic          upd_taken_r;
    logic          flush_r;
    logic [31:0]   flush_pc_r;
    logic          err_r;

    assign push_entry_s = '{pc: pred_pc, taken: pred_taken, target: pred_target};
    assign full         = q_full_s && !commit_valid;

    circ_queue #(.T(brq_entry_t), .DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .clear     (clear_s),
        .head_data (head_s),
        .count     (count_s),
        .full      (q_full_s),
        .empty     (empty_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= BRQ_RUN;
        else     state_r <= state_next_s;
    end

    // FSM next state: a mispredicting commit spends exactly one cycle in FLUSH.
    always_comb begin
        state_next_s = BRQ_RUN;
        case (state_r)
            BRQ_RUN:   state_next_s = mispredict_s ? BRQ_FLUSH : BRQ_RUN;
            BRQ_FLUSH: state_next_s = BRQ_RUN;
            default:   state_next_s = BRQ_RUN;
        endcase
    end

    // FSM outputs: queue controls; everything is ignored while the frontend is flushing.
    always_comb begin
        push_s       = 1'b0;
        pop_s        = 1'b0;
        clear_s      = 1'b0;
        mispredict_s = 1'b0;
        err_set_s    = 1'b0;
        case (state_r)
            BRQ_RUN: begin
                pop_s        = commit_valid && !empty_s;
                err_set_s    = commit_valid && empty_s;
                mispredict_s = pop_s && brq_mispredict(head_s, commit_next_pc);
                clear_s      = mispredict_s;
                push_s       = pred_valid && !full && !mispredict_s;
            end
            BRQ_FLUSH: begin
                push_s = 1'b0;
                pop_s  = 1'b0;
            end
            default: begin
                push_s = 1'b0;
                pop_s  = 1'b0;
            end
        endcase
    end

    // Registered commit results: one-cycle pulses plus the sticky empty-commit error.
    always_ff @(posedge clk) begin
        if (rst) begin
            upd_load_r  <= 1'b0;
            upd_pc_r    <= 32'h0;
            upd_taken_r <= 1'b0;
            flush_r     <= 1'b0;
            flush_pc_r  <= 32'h0;
            err_r       <= 1'b0;
        end else begin
            upd_load_r  <= pop_s;
            upd_pc_r    <= pop_s ? head_s.pc : 32'h0;
            upd_taken_r <= pop_s && commit_taken;
            flush_r     <= mispredict_s;
            flush_pc_r  <= mispredict_s ? commit_next_pc : 32'h0;
            err_r       <= err_r || err_set_s;
        end
    end

    assign upd_load  = upd_load_r;
    assign upd_pc    = upd_pc_r;
    assign upd_taken = upd_taken_r;
    assign flush     = flush_r;
    assign flush_pc  = flush_pc_r;
    assign err       = err_r;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Randomized and directed bench for branch_resolve_queue against a queue-based
// reference model of the commit/flush rules.
module tb_branch_resolve_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pred_valid = 1'b0;
    logic [31:0] pred_pc = 32'h0;
    logic        pred_taken = 1'b0;
    logic [31:0] pred_target = 32'h0;
    logic        full;
    logic        commit_valid = 1'b0;
    logic        commit_taken = 1'b0;
    logic [31:0] commit_next_pc = 32'h0;
    logic        upd_load;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        flush;
    logic [31:0] flush_pc;
    logic        err;

    branch_resolve_queue dut (
        .clk            (clk),
        .rst            (rst),
        .pred_valid     (pred_valid),
        .pred_pc        (pred_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .full           (full),
        .commit_valid   (commit_valid),
        .commit_taken   (commit_taken),
        .commit_next_pc (commit_next_pc),
        .upd_load       (upd_load),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .flush          (flush),
        .flush_pc       (flush_pc),
        .err            (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] target;
    } ent_t;

    localparam int DEPTH = 16;

    ent_t mq[$];
    bit   m_flush_cyc = 1'b0;
    bit   m_err = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: apply inputs, check combinational full, advance model, check registered outputs.
    task automatic step(input logic pv, input logic [31:0] ppc, input logic [31:0] ptg,
                        input logic cv, input logic ctk, input logic [31:0] cnpc, input logic r);
        bit          e_full, pop, push, mis, e_upd, e_flush, e_utk;
        logic [31:0] e_upc, e_fpc;
        ent_t        e;
        @(negedge clk);
        pred_valid = pv; pred_pc = ppc; pred_target = ptg; pred_taken = ptg[2];
        commit_valid = cv; commit_taken = ctk; commit_next_pc = cnpc; rst = r;
        #1;
        e_full = (mq.size() == DEPTH) && !cv;
        check_eq("full", {31'h0, full}, {31'h0, e_full});
        e_upd = 0; e_flush = 0; e_utk = 0; e_upc = 32'h0; e_fpc = 32'h0; mis = 0;
        if (r) begin
            mq.delete(); m_err = 0; m_flush_cyc = 0;
        end else if (m_flush_cyc) begin
            m_flush_cyc = 0;
        end else begin
            pop  = cv && mq.size() != 0;
            push = pv && !e_full;
            if (cv && mq.size() == 0) m_err = 1;
            if (pop) begin
                e = mq.pop_front();
                e_upd = 1; e_upc = e.pc; e_utk = ctk;
                mis = (e.target != cnpc);
                if (mis) begin e_flush = 1; e_fpc = cnpc; end
            end
            if (mis) begin
                mq.delete(); m_flush_cyc = 1;
            end else if (push) begin
                mq.push_back('{ppc, ptg});
            end
        end
        @(posedge clk);
        #1;
        check_eq("upd_load", {31'h0, upd_load}, {31'h0, e_upd});
        if (e_upd) begin
            check_eq("upd_pc", upd_pc, e_upc);
            check_eq("upd_taken", {31'h0, upd_taken}, {31'h0, e_utk});
        end
        check_eq("flush", {31'h0, flush}, {31'h0, e_flush});
        if (e_flush) check_eq("flush_pc", flush_pc, e_fpc);
        check_eq("err", {31'h0, err}, {31'h0, m_err});
        check_eq("count", 32'(dut.count_s), 32'(mq.size()));
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic push_one(input logic [31:0] pc, input logic [31:0] tg);
        step(1'b1, pc, tg, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        logic [31:0] npc;
        // Reset state
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("reset_full", {31'h0, full}, 32'h0);

        // 1: correct prediction
        push_one(32'h60, 32'h80);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h80, 1'b0);
        check_eq("t1_upd_pc", upd_pc, 32'h60);
        idle();

        // 2: mispredict with a wrong-path push in the commit cycle
        push_one(32'h40, 32'h44);
        step(1'b1, 32'h200, 32'h204, 1'b1, 1'b1, 32'h100, 1'b0);
        check_eq("t2_flush_pc", flush_pc, 32'h100);
        idle();
        idle();

        // 3: fill, overflow push, then push+commit across the wrap
        for (int i = 0; i < DEPTH; i++) push_one(32'h1000 + 32'(i) * 32'h10, 32'h1004 + 32'(i) * 32'h10);
        check_eq("t3_full", {31'h0, full}, 32'h1);
        push_one(32'hdead0, 32'hdead4);
        for (int i = 0; i < 20; i++) begin
            npc = mq[0].target;
            step(1'b1, 32'h2000 + 32'(i) * 32'h10, 32'h2004 + 32'(i) * 32'h10, 1'b1, 1'b0, npc, 1'b0);
        end
        while (mq.size() != 0) begin
            npc = mq[0].target;
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, npc, 1'b0);
        end
        idle();

        // 4: commit while empty sets a sticky error
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h10, 1'b0);
        idle();
        idle();
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);

        // 5: reset in the commit cycle of a mispredict
        push_one(32'h300, 32'h304);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h999, 1'b1);
        idle();

        // 6: inputs ignored during the flush cycle
        push_one(32'h500, 32'h504);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h700, 1'b0);
        step(1'b1, 32'h550, 32'h554, 1'b1, 1'b0, 32'h554, 1'b0);
        push_one(32'h600, 32'h604);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h604, 1'b0);
        check_eq("t6_upd_pc", upd_pc, 32'h600);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic        pv, cv, r;
            logic [31:0] ppc;
            pv  = ($urandom % 3) != 0;
            cv  = ($urandom % 2) == 0;
            r   = ($urandom % 300) == 0;
            ppc = $urandom & 32'hffff_fffc;
            if (mq.size() != 0 && ($urandom % 8) != 0) npc = mq[0].target;
            else npc = $urandom & 32'hffff_fffc;
            step(pv, ppc, ppc + (($urandom % 2) ? 32'h4 : 32'h40), cv, 1'($urandom % 2), npc, r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
